// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, state encoding and round-robin search for the data-memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int NB_REQ      = 4;
   localparam int NB_REQ_ID   = 2;
   localparam int NB_HOLD_CNT = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   // Returns {found, index}: first set request scanning upward from ptr, wrapping mod NB_REQ.
   function automatic logic [NB_REQ_ID:0] rr_pick(input logic [NB_REQ-1:0]    req,
                                                  input logic [NB_REQ_ID-1:0] ptr);
      logic                 found;
      logic [NB_REQ_ID-1:0] idx;
      logic [NB_REQ_ID-1:0] cand;
      found = 1'b0;
      idx   = ptr;
      for (int i = 0; i < NB_REQ; i++) begin
         cand = ptr + NB_REQ_ID'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle between the memory-port requesters and the arbiter.
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic [NB_REQ-1:0]    req;
   logic [NB_REQ-1:0]    gnt;
   logic [NB_REQ_ID-1:0] gnt_id;
   logic                 busy;
   logic                 preempt;

   modport master (output req, input gnt, gnt_id, busy, preempt);
   modport slave  (input req, output gnt, gnt_id, busy, preempt);

endinterface

// File: rtl/mem_port_arbiter_decoder.sv
// Enabled 2-to-4 one-hot decoder driving the memory-port select lines.
module decoder_2to4
   import mem_port_arbiter_pkg::*;
(
   input  logic                 en,
   input  logic [NB_REQ_ID-1:0] sel,
   output logic [NB_REQ-1:0]    dec
);

   always_comb begin
      dec = '0;
      if (en) dec[sel] = 1'b1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner selection for the shared data-memory port, with bounded hold
// and a one-cycle dead gap between owners.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | no owner; arbitrate every cycle
//   ST_GRANT   | owner holds the port; cnt tracks consecutive grant cycles
//   ST_RELEASE | dead cycle between owners; arbitrates exactly like ST_IDLE
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   mem_port_arbiter_if.slave  bus
);

   localparam logic [NB_HOLD_CNT-1:0] CNT_LAST = NB_HOLD_CNT'(MAX_HOLD - 1);

   state_t                 state, nxt_state;
   logic [NB_REQ_ID-1:0]   owner, nxt_owner;
   logic [NB_REQ_ID-1:0]   ptr, nxt_ptr;
   logic [NB_HOLD_CNT-1:0] cnt, nxt_cnt;
   logic                   preempt_q, nxt_preempt;
   logic [NB_REQ_ID:0]     pick;
   logic [NB_REQ-1:0]      gnt_dec;

   assign pick = rr_pick(bus.req, ptr);

   decoder_2to4 u_gnt_dec (
      .en  (state == ST_GRANT),
      .sel (owner),
      .dec (gnt_dec)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         owner     <= '0;
         ptr       <= '0;
         cnt       <= '0;
         preempt_q <= 1'b0;
      end else begin
         state     <= nxt_state;
         owner     <= nxt_owner;
         ptr       <= nxt_ptr;
         cnt       <= nxt_cnt;
         preempt_q <= nxt_preempt;
      end
   end

   // gnt_dec equals one-hot(owner) in ST_GRANT, so it doubles as the competitor mask.
   always_comb begin
      nxt_state   = state;
      nxt_owner   = owner;
      nxt_ptr     = ptr;
      nxt_cnt     = cnt;
      nxt_preempt = 1'b0;
      case (state)
         ST_IDLE, ST_RELEASE: begin
            if (pick[NB_REQ_ID]) begin
               nxt_state = ST_GRANT;
               nxt_owner = pick[NB_REQ_ID-1:0];
               nxt_ptr   = pick[NB_REQ_ID-1:0] + NB_REQ_ID'(1);
               nxt_cnt   = '0;
            end else begin
               nxt_state = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (!bus.req[owner]) begin
               nxt_state = ST_RELEASE;
            end else if ((cnt == CNT_LAST) && (|(bus.req & ~gnt_dec))) begin
               nxt_state   = ST_RELEASE;
               nxt_preempt = 1'b1;
            end else if (cnt != CNT_LAST) begin
               nxt_cnt = cnt + NB_HOLD_CNT'(1);
            end
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.gnt     = gnt_dec;
      bus.gnt_id  = owner;
      bus.busy    = (state == ST_GRANT);
      bus.preempt = preempt_q;
   end

endmodule
